wb_stage: RTL and testbench

- Writeback stage of the pipelined CPU. Sits downstream of the register-file write-address/enable controller and directly upstream of the register file write port.
- Captures one retiring instruction (destination select, write enable, ALU result, PC, load attributes) through a valid/ready handshake.
- For loads, waits for data-memory read data, then aligns and extends it.
- Drives a single-cycle register-file write, a pending-destination hazard indication, and a retire counter.

---
 rtl/wb_stage.sv | 149 ++++++++++++++
 tb/tb_wb_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: captures one retiring instruction and waits for load data when needed.
// It then drives a single-cycle register-file write, the pending-destination hazard and the retire count.
module wb_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                w_clock,
  input  logic                w_reset_n,
  input  logic                w_in_valid,
  output logic                w_in_ready,
  input  logic                w_wen_in,
  input  logic                w_waddr_sel,
  input  logic                w_link_op,
  input  logic                w_load_op,
  input  logic [RADDR_W-1:0]  w_rt,
  input  logic [RADDR_W-1:0]  w_rd,
  input  logic [DATA_W-1:0]   w_alu_result,
  input  logic [DATA_W-1:0]   w_pc,
  input  logic [1:0]          w_load_size,
  input  logic                w_load_unsigned,
  input  logic [1:0]          w_addr_lo,
  input  logic                w_dmem_rvalid,
  input  logic [DATA_W-1:0]   w_dmem_rdata,
  output logic                w_rf_wen,
  output logic [RADDR_W-1:0]  w_rf_waddr,
  output logic [DATA_W-1:0]   w_rf_wdata,
  output logic                w_pend_valid,
  output logic [RADDR_W-1:0]  w_pend_addr,
  output logic                w_misalign_err,
  output logic [RETIRE_W-1:0] w_retire_count
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t               state;
  logic                 wen_q;
  logic                 link_q;
  logic                 load_q;
  logic                 unsigned_q;
  logic [1:0]           size_q;
  logic [1:0]           addr_lo_q;
  logic [RADDR_W-1:0]   dest_q;
  logic [DATA_W-1:0]    alu_q;
  logic [DATA_W-1:0]    pc_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [RETIRE_W-1:0]  retire_q;

  logic                 accept;
  logic                 commit;
  logic                 will_write;
  logic                 misaligned;
  logic [RADDR_W-1:0]   dest_c;
  logic [7:0]           lane8;
  logic [15:0]          lane16;
  logic [DATA_W-1:0]    load_data;

  assign w_in_ready = w_reset_n & (state != WAIT_MEM);
  assign accept     = w_in_valid & w_in_ready;
  assign commit     = (state == COMMIT);

  // Destination resolved at capture so the hazard address is stable during the load wait.
  assign dest_c = w_link_op   ? RADDR_W'(LINK_REG) :
                  w_waddr_sel ? w_rt : w_rd;

  assign will_write = wen_q & (dest_q != '0);
  assign misaligned = load_q & (((size_q == 2'b01) & addr_lo_q[0]) |
                                (size_q[1] & (addr_lo_q != 2'b00)));

  // Little-endian lane extraction and sign/zero extension.
  always_comb begin
    lane8     = rdata_q[7:0];
    lane16    = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_data = '0;
    case (addr_lo_q)
      2'd0:    lane8 = rdata_q[7:0];
      2'd1:    lane8 = rdata_q[15:8];
      2'd2:    lane8 = rdata_q[23:16];
      default: lane8 = rdata_q[31:24];
    endcase
    case (size_q)
      2'b00:   load_data = unsigned_q ? DATA_W'(lane8)  : DATA_W'($signed(lane8));
      2'b01:   load_data = unsigned_q ? DATA_W'(lane16) : DATA_W'($signed(lane16));
      default: load_data = unsigned_q ? DATA_W'(rdata_q[31:0]) : DATA_W'($signed(rdata_q[31:0]));
    endcase
  end

  always_comb begin
    w_rf_wen       = commit & will_write & ~misaligned;
    w_rf_waddr     = commit ? dest_q : '0;
    w_rf_wdata     = '0;
    if (commit) begin
      if (link_q)      w_rf_wdata = pc_q + DATA_W'(8);
      else if (load_q) w_rf_wdata = load_data;
      else             w_rf_wdata = alu_q;
    end
    w_misalign_err = commit & misaligned;
    w_pend_valid   = (state != IDLE) & will_write;
    w_pend_addr    = w_pend_valid ? dest_q : '0;
  end

  assign w_retire_count = retire_q;

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state      <= IDLE;
      wen_q      <= 1'b0;
      link_q     <= 1'b0;
      load_q     <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_lo_q  <= 2'b00;
      dest_q     <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
      rdata_q    <= '0;
      retire_q   <= '0;
    end else begin
      if (commit) retire_q <= retire_q + RETIRE_W'(1);
      case (state)
        WAIT_MEM: begin
          if (w_dmem_rvalid) begin
            rdata_q <= w_dmem_rdata;
            state   <= COMMIT;
          end
        end
        IDLE, COMMIT: begin
          if (accept) begin
            wen_q      <= w_wen_in;
            link_q     <= w_link_op;
            load_q     <= w_load_op;
            unsigned_q <= w_load_unsigned;
            size_q     <= w_load_size;
            addr_lo_q  <= w_addr_lo;
            dest_q     <= dest_c;
            alu_q      <= w_alu_result;
            pc_q       <= w_pc;
            state      <= w_load_op ? WAIT_MEM : COMMIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push expected writes, a negedge monitor checks them.
module tb_wb_stage;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        w_clock = 1'b0;
  logic        w_reset_n = 1'b0;
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic        w_wen_in = 1'b0;
  logic        w_waddr_sel = 1'b0;
  logic        w_link_op = 1'b0;
  logic        w_load_op = 1'b0;
  logic [4:0]  w_rt = '0;
  logic [4:0]  w_rd = '0;
  logic [31:0] w_alu_result = '0;
  logic [31:0] w_pc = '0;
  logic [1:0]  w_load_size = '0;
  logic        w_load_unsigned = 1'b0;
  logic [1:0]  w_addr_lo = '0;
  logic        w_dmem_rvalid = 1'b0;
  logic [31:0] w_dmem_rdata = '0;
  logic        w_rf_wen;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_pend_valid;
  logic [4:0]  w_pend_addr;
  logic        w_misalign_err;
  logic [31:0] w_retire_count;

  wb_stage dut (
    .w_clock(w_clock), .w_reset_n(w_reset_n),
    .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
    .w_wen_in(w_wen_in), .w_waddr_sel(w_waddr_sel), .w_link_op(w_link_op),
    .w_load_op(w_load_op), .w_rt(w_rt), .w_rd(w_rd),
    .w_alu_result(w_alu_result), .w_pc(w_pc), .w_load_size(w_load_size),
    .w_load_unsigned(w_load_unsigned), .w_addr_lo(w_addr_lo),
    .w_dmem_rvalid(w_dmem_rvalid), .w_dmem_rdata(w_dmem_rdata),
    .w_rf_wen(w_rf_wen), .w_rf_waddr(w_rf_waddr), .w_rf_wdata(w_rf_wdata),
    .w_pend_valid(w_pend_valid), .w_pend_addr(w_pend_addr),
    .w_misalign_err(w_misalign_err), .w_retire_count(w_retire_count)
  );

  always #5 w_clock = ~w_clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int exp_retire = 0;
  wr_t exp_q[$];
  int  mis_q[$];
  int  wen_cyc[$];

  always @(posedge w_clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and misalignment pulse must match a queued expectation.
  always @(negedge w_clock) begin
    if (w_reset_n) begin
      if (w_rf_wen) begin
        wen_cyc.push_back(cycle);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", w_rf_waddr, w_rf_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(w_rf_waddr), 32'(e.addr));
          chk("wr_data", w_rf_wdata, e.data);
        end
      end
      if (w_misalign_err) begin
        if (mis_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_misalign: got 1 expected 0");
        end else begin
          void'(mis_q.pop_front());
          checks++;
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic sel, input logic link, input logic load,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [1:0] size, input logic uns,
                       input logic [1:0] alo);
    int n = 0;
    w_wen_in = wen; w_waddr_sel = sel; w_link_op = link; w_load_op = load;
    w_rt = rt; w_rd = rd; w_alu_result = alu; w_pc = pc;
    w_load_size = size; w_load_unsigned = uns; w_addr_lo = alo;
    w_in_valid = 1'b1;
    while (!w_in_ready && n < 50) begin
      @(posedge w_clock); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready 0 expected 1");
    end
    @(posedge w_clock); #1;
    w_in_valid = 1'b0;
    exp_retire++;
  endtask

  task automatic mem_resp(input int delay, input logic [31:0] data);
    repeat (delay) begin @(posedge w_clock); #1; end
    w_dmem_rvalid = 1'b1; w_dmem_rdata = data;
    @(posedge w_clock); #1;
    w_dmem_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge w_clock); #1; end
  endtask

  function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    return w;
  endfunction

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(w_in_ready), 0);
    chk("rst_wen", 32'(w_rf_wen), 0);
    chk("rst_pend", 32'(w_pend_valid), 0);
    chk("rst_retire", w_retire_count, 0);
    @(posedge w_clock); #1;
    w_reset_n = 1'b1;
    idle(1);
    chk("idle_in_ready", 32'(w_in_ready), 1);

    // Non-load handoff
    exp_q.push_back(mk(5'd5, 32'h0000_1234));
    issue(1, 0, 0, 0, 5'd0, 5'd5, 32'h1234, 32'h0, 2'd0, 0, 2'd0);
    idle(1);
    chk("retire_after_first", w_retire_count, 32'(exp_retire));

    // Back-to-back non-loads
    wen_cyc.delete();
    exp_q.push_back(mk(5'd1, 32'hAAAA_0001));
    exp_q.push_back(mk(5'd2, 32'hBBBB_0002));
    exp_q.push_back(mk(5'd3, 32'hCCCC_0003));
    issue(1, 0, 0, 0, 5'd0, 5'd1, 32'hAAAA_0001, 32'h0, 2'd0, 0, 2'd0);
    chk("b2b_ready1", 32'(w_in_ready), 1);
    issue(1, 1, 0, 0, 5'd2, 5'd9, 32'hBBBB_0002, 32'h0, 2'd0, 0, 2'd0);
    chk("b2b_ready2", 32'(w_in_ready), 1);
    issue(1, 0, 0, 0, 5'd0, 5'd3, 32'hCCCC_0003, 32'h0, 2'd0, 0, 2'd0);
    chk("b2b_ready3", 32'(w_in_ready), 1);
    idle(2);
    chk("b2b_writes", 32'(wen_cyc.size()), 3);
    if (wen_cyc.size() == 3) chk("b2b_consecutive", 32'(wen_cyc[2] - wen_cyc[0]), 2);

    // Load byte, signed, lane 2
    exp_q.push_back(mk(5'd8, 32'hFFFF_FFF4));
    issue(1, 1, 0, 1, 5'd8, 5'd0, 32'h0, 32'h0, 2'd0, 0, 2'd2);
    chk("wait_in_ready", 32'(w_in_ready), 0);
    chk("wait_pend_valid", 32'(w_pend_valid), 1);
    chk("wait_pend_addr", 32'(w_pend_addr), 8);
    mem_resp(2, 32'h12F4_5678);
    idle(2);

    // Half loads and unsigned byte
    exp_q.push_back(mk(5'd10, 32'h0000_8001));
    issue(1, 0, 0, 1, 5'd0, 5'd10, 32'h0, 32'h0, 2'd1, 1, 2'd2);
    mem_resp(0, 32'h8001_0000);
    exp_q.push_back(mk(5'd11, 32'hFFFF_8000));
    issue(1, 1, 0, 1, 5'd11, 5'd0, 32'h0, 32'h0, 2'd1, 0, 2'd0);
    mem_resp(1, 32'h0000_8000);
    exp_q.push_back(mk(5'd12, 32'h0000_00AB));
    issue(1, 1, 0, 1, 5'd12, 5'd0, 32'h0, 32'h0, 2'd0, 1, 2'd3);
    mem_resp(0, 32'hAB00_0000);
    idle(2);

    // Link write and r0 suppression
    exp_q.push_back(mk(5'd31, 32'h0000_0408));
    issue(1, 0, 1, 0, 5'd4, 5'd3, 32'hDEAD_BEEF, 32'h0000_0400, 2'd0, 0, 2'd0);
    issue(1, 0, 0, 0, 5'd0, 5'd0, 32'hDEAD_0000, 32'h0, 2'd0, 0, 2'd0);
    idle(2);
    chk("retire_r0", w_retire_count, 32'(exp_retire));

    // rvalid while idle is ignored
    mem_resp(0, 32'h5555_5555);
    idle(1);

    // Misaligned word load
    mis_q.push_back(1);
    issue(1, 1, 0, 1, 5'd9, 5'd0, 32'h0, 32'h0, 2'd2, 0, 2'd1);
    mem_resp(1, 32'h1111_2222);
    idle(2);
    chk("misalign_seen", 32'(mis_q.size()), 0);
    chk("retire_misalign", w_retire_count, 32'(exp_retire));

    // Reset while waiting for memory
    issue(1, 1, 0, 1, 5'd7, 5'd0, 32'h0, 32'h0, 2'd2, 0, 2'd0);
    exp_retire = 0;
    idle(1);
    w_reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(w_in_ready), 0);
    idle(1);
    w_reset_n = 1'b1;
    mem_resp(1, 32'h7777_7777);
    idle(2);
    chk("midrst_ready", 32'(w_in_ready), 1);
    chk("midrst_retire", w_retire_count, 0);
    chk("midrst_pend", 32'(w_pend_valid), 0);

    chk("pending_writes", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
